// File: rtl/fp_comparator_arbiter.sv
// Shares one FpComparator between two requesters behind a single tagged response channel.
// Define FP_CMP_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

package fp_cmp_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] word_t;
  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } fflags_t;
  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_LT  = 3'd1,
    CMP_LE  = 3'd2,
    CMP_MIN = 3'd3,
    CMP_MAX = 3'd4
  } FpComparatorCommand;
endpackage

module FpComparator
  import fp_cmp_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int FRACTION_WIDTH = 23,
  parameter int WIDTH          = 1 + EXPONENT_WIDTH + FRACTION_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  FpComparatorCommand command,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  output word_t              intResult,
  output logic [WIDTH-1:0]   fpResult,
  output fflags_t            flags
);
  localparam logic [WIDTH-1:0] CANONICAL_NAN =
    {1'b0, {EXPONENT_WIDTH{1'b1}}, 1'b1, {(FRACTION_WIDTH-1){1'b0}}};

  logic w_unused;
  logic w_aNan, w_bNan, w_aSnan, w_bSnan, w_anyNan, w_anySnan;
  logic w_bothZero, w_magLt, w_magEq, w_ltTotal, w_lt, w_eq;

  // Clock and reset exist only to keep the shared-unit port shape; the datapath is combinational.
  assign w_unused  = clk ^ rst;

  assign w_aNan    = (&src1[WIDTH-2 -: EXPONENT_WIDTH]) && (|src1[FRACTION_WIDTH-1:0]);
  assign w_bNan    = (&src2[WIDTH-2 -: EXPONENT_WIDTH]) && (|src2[FRACTION_WIDTH-1:0]);
  assign w_aSnan   = w_aNan && !src1[FRACTION_WIDTH-1];
  assign w_bSnan   = w_bNan && !src2[FRACTION_WIDTH-1];
  assign w_anyNan  = w_aNan || w_bNan;
  assign w_anySnan = w_aSnan || w_bSnan;

  assign w_bothZero = (~|src1[WIDTH-2:0]) && (~|src2[WIDTH-2:0]);
  assign w_magLt    = src1[WIDTH-2:0] < src2[WIDTH-2:0];
  assign w_magEq    = src1[WIDTH-2:0] == src2[WIDTH-2:0];
  // Total order with -0 below +0; min/max rely on it, Lt/Le mask the signed-zero case.
  assign w_ltTotal  = (src1[WIDTH-1] != src2[WIDTH-1]) ? src1[WIDTH-1] :
                      (src1[WIDTH-1] ? !(w_magLt || w_magEq) : w_magLt);
  assign w_lt       = w_ltTotal && !w_bothZero;
  assign w_eq       = (src1 == src2) || w_bothZero;

  always_comb begin
    intResult = '0;
    fpResult  = '0;
    flags     = '0;
    case (command)
      CMP_EQ: begin
        intResult[0] = !w_anyNan && w_eq;
        flags.NV     = w_anySnan;
      end
      CMP_LT: begin
        intResult[0] = !w_anyNan && w_lt;
        flags.NV     = w_anyNan;
      end
      CMP_LE: begin
        intResult[0] = !w_anyNan && (w_lt || w_eq);
        flags.NV     = w_anyNan;
      end
      CMP_MIN, CMP_MAX: begin
        flags.NV = w_anySnan;
        if (w_aNan && w_bNan)                       fpResult = CANONICAL_NAN;
        else if (w_aNan)                            fpResult = src2;
        else if (w_bNan)                            fpResult = src1;
        else if ((command == CMP_MIN) == w_ltTotal) fpResult = src1;
        else                                        fpResult = src2;
      end
      default: ;
    endcase
  end
endmodule

module fp_comparator_arbiter
  import fp_cmp_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int FRACTION_WIDTH = 23,
  parameter int WIDTH          = 1 + EXPONENT_WIDTH + FRACTION_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               reqValid,
  output logic [1:0]               reqReady,
  input  FpComparatorCommand [1:0] reqCommand,
  input  logic [1:0][WIDTH-1:0]    reqSrc1,
  input  logic [1:0][WIDTH-1:0]    reqSrc2,
  output logic                     respValid,
  input  logic                     respReady,
  output logic                     respId,
  output word_t                    respIntResult,
  output logic [WIDTH-1:0]         respFpResult,
  output fflags_t                  respFlags
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             r_state, w_nextState;
  FpComparatorCommand r_cmd;
  logic [WIDTH-1:0]   r_src1, r_src2, r_respFpResult;
  logic               r_id, r_respId;
  word_t              r_respIntResult;
  fflags_t            r_respFlags;
  logic               w_canGrant, w_grant, w_winner;
  word_t              w_intResult;
  logic [WIDTH-1:0]   w_fpResult;
  fflags_t            w_flags;

`ifdef FP_CMP_ARB_ROUND_ROBIN_EN
  logic r_lastGrant;

  assign w_winner = (&reqValid) ? ~r_lastGrant : ~reqValid[0];

  always_ff @(posedge clk) begin
    if (rst)          r_lastGrant <= 1'b1;
    else if (w_grant) r_lastGrant <= w_winner;
  end
`else
  assign w_winner = ~reqValid[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_canGrant  = 1'b0;
    case (r_state)
      IDLE: begin
        w_canGrant = 1'b1;
        if (|reqValid) w_nextState = EXEC;
      end
      EXEC: w_nextState = RESP;
      RESP: begin
        if (respReady) begin
          w_canGrant  = 1'b1;
          w_nextState = (|reqValid) ? EXEC : IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Reset masks the handshake so a request raised during reset is never told it was taken.
  assign w_grant  = w_canGrant && (|reqValid) && !rst;
  assign reqReady = w_grant ? (w_winner ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd           <= CMP_EQ;
      r_src1          <= '0;
      r_src2          <= '0;
      r_id            <= 1'b0;
      r_respId        <= 1'b0;
      r_respIntResult <= '0;
      r_respFpResult  <= '0;
      r_respFlags     <= '0;
    end else begin
      if (w_grant) begin
        r_cmd  <= reqCommand[w_winner];
        r_src1 <= reqSrc1[w_winner];
        r_src2 <= reqSrc2[w_winner];
        r_id   <= w_winner;
      end
      if (r_state == EXEC) begin
        r_respId        <= r_id;
        r_respIntResult <= w_intResult;
        r_respFpResult  <= w_fpResult;
        r_respFlags     <= w_flags;
      end
    end
  end

  FpComparator #(
    .EXPONENT_WIDTH(EXPONENT_WIDTH),
    .FRACTION_WIDTH(FRACTION_WIDTH),
    .WIDTH         (WIDTH)
  ) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .command  (r_cmd),
    .src1     (r_src1),
    .src2     (r_src2),
    .intResult(w_intResult),
    .fpResult (w_fpResult),
    .flags    (w_flags)
  );

  assign respValid     = (r_state == RESP);
  assign respId        = r_respId;
  assign respIntResult = r_respIntResult;
  assign respFpResult  = r_respFpResult;
  assign respFlags     = r_respFlags;
endmodule

// File: tb/tb_fp_comparator_arbiter.sv
// Bench for fp_comparator_arbiter: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model of arbitration and IEEE compare rules.
module tb_fp_comparator_arbiter;
  import fp_cmp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [1:0]               reqValid, reqReady;
  FpComparatorCommand [1:0] reqCommand;
  logic [1:0][31:0]         reqSrc1, reqSrc2;
  logic                     respValid, respReady, respId;
  word_t                    respIntResult;
  logic [31:0]              respFpResult;
  fflags_t                  respFlags;
  logic [4:0]               flagBits;

  assign flagBits = respFlags;

  int nCompared   = 0;
  int nMismatched = 0;

  fp_comparator_arbiter #(.EXPONENT_WIDTH(8), .FRACTION_WIDTH(23), .WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .reqValid     (reqValid),
    .reqReady     (reqReady),
    .reqCommand   (reqCommand),
    .reqSrc1      (reqSrc1),
    .reqSrc2      (reqSrc2),
    .respValid    (respValid),
    .respReady    (respReady),
    .respId       (respId),
    .respIntResult(respIntResult),
    .respFpResult (respFpResult),
    .respFlags    (respFlags)
  );

  typedef struct {
    int          readyAt;
    logic        id;
    logic [31:0] ir;
    logic [31:0] fr;
    logic [4:0]  fl;
  } resp_t;

  resp_t q[$];
  int    cyc = 0;
`ifdef FP_CMP_ARB_ROUND_ROBIN_EN
  logic  mLast = 1'b1;
`endif

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference compare: ordered values mapped onto a signed integer line, NaNs handled first.
  function automatic void refModel(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] ir, output logic [31:0] fr, output logic [4:0] fl);
    bit nanA  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bit nanB  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    bit snanA = nanA && !a[22];
    bit snanB = nanB && !b[22];
    longint ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    longint kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    bit ordered = !nanA && !nanB;
    bit nv = 1'b0;
    ir = 32'd0;
    fr = 32'd0;
    case (cmd)
      3'd0: begin ir[0] = ordered && (ka == kb); nv = snanA || snanB; end
      3'd1: begin ir[0] = ordered && (ka <  kb); nv = !ordered; end
      3'd2: begin ir[0] = ordered && (ka <= kb); nv = !ordered; end
      3'd3, 3'd4: begin
        nv = snanA || snanB;
        if (nanA && nanB) fr = 32'h7FC00000;
        else if (nanA)    fr = b;
        else if (nanB)    fr = a;
        else if (cmd == 3'd3) fr = ((ka < kb) || (ka == kb && a[31]))  ? a : b;
        else                  fr = ((ka > kb) || (ka == kb && !a[31])) ? a : b;
      end
      default: ;
    endcase
    fl = {nv, 4'b0000};
  endfunction

  // Per-cycle scoreboard: a request granted in cycle N must be presented from cycle N+2 until accepted.
  always @(negedge clk) begin
    logic       vis, allow, w;
    logic [1:0] expReady;
    resp_t      r;
    vis = 1'b0;
    if (q.size() > 0) vis = (cyc >= q[0].readyAt);
    allow    = (q.size() == 0) || (vis && respReady);
    expReady = 2'b00;
    w        = 1'b0;
    if (allow && (|reqValid) && !rst) begin
      if (reqValid == 2'b11) begin
`ifdef FP_CMP_ARB_ROUND_ROBIN_EN
        w = ~mLast;
`else
        w = 1'b0;
`endif
      end else begin
        w = reqValid[1];
      end
      expReady = w ? 2'b10 : 2'b01;
    end
    checkOutput("model.reqReady", {30'b0, reqReady}, {30'b0, expReady});
    checkOutput("model.respValid", {31'b0, respValid}, {31'b0, vis});
    if (vis) begin
      checkOutput("model.respId", {31'b0, respId}, {31'b0, q[0].id});
      checkOutput("model.respIntResult", respIntResult, q[0].ir);
      checkOutput("model.respFpResult", respFpResult, q[0].fr);
      checkOutput("model.respFlags", {27'b0, flagBits}, {27'b0, q[0].fl});
    end
    if (rst) begin
      q.delete();
`ifdef FP_CMP_ARB_ROUND_ROBIN_EN
      mLast = 1'b1;
`endif
    end else begin
      if (vis && respReady) void'(q.pop_front());
      if (expReady != 2'b00) begin
        refModel(reqCommand[w], reqSrc1[w], reqSrc2[w], r.ir, r.fr, r.fl);
        r.readyAt = cyc + 2;
        r.id      = w;
        q.push_back(r);
`ifdef FP_CMP_ARB_ROUND_ROBIN_EN
        mLast = w;
`endif
      end
    end
    cyc++;
  end

  task automatic applyStimulus(input logic [1:0] v, input logic rr);
    @(posedge clk);
    #1;
    reqValid  = v;
    respReady = rr;
  endtask

  task automatic setReq(input int i, input FpComparatorCommand c, input logic [31:0] a, input logic [31:0] b);
    reqCommand[i] = c;
    reqSrc1[i]    = a;
    reqSrc2[i]    = b;
  endtask

  task automatic runOp(input string name, input int id, input FpComparatorCommand c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eInt, input logic [31:0] eFp, input logic [4:0] eFl);
    int lat;
    bit got;
    logic [1:0] onehot;
    onehot = (id == 0) ? 2'b01 : 2'b10;
    applyStimulus(onehot, 1'b1);
    setReq(id, c, a, b);
    @(negedge clk);
    checkOutput({name, ".grant"}, {30'b0, reqReady}, {30'b0, onehot});
    applyStimulus(2'b00, 1'b1);
    got = 1'b0;
    lat = 1;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      if (respValid) got = 1'b1;
      else           lat++;
    end
    checkOutput({name, ".respSeen"}, {31'b0, got}, 32'd1);
    if (got) begin
      checkOutput({name, ".latency"}, 32'(lat), 32'd2);
      checkOutput({name, ".respId"}, {31'b0, respId}, 32'(id));
      checkOutput({name, ".int"}, respIntResult, eInt);
      checkOutput({name, ".fp"}, respFpResult, eFp);
      checkOutput({name, ".flags"}, {27'b0, flagBits}, {27'b0, eFl});
    end
  endtask

  function automatic logic [31:0] randOperand();
    logic [31:0] pool [10] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000, 32'h40000000,
                               32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800001, 32'hFFA00000};
    int sel = $urandom_range(0, 14);
    if (sel < 10) return pool[sel];
    if (sel < 13) return {1'($urandom), 8'd127, 20'd0, 3'($urandom)};
    return $urandom();
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gIdx[$];
    int gCyc[$];
    int expSeq[3];
    bit got;

    rst       = 1'b1;
    reqValid  = 2'b00;
    respReady = 1'b1;
    reqCommand[0] = CMP_EQ;
    reqCommand[1] = CMP_EQ;
    reqSrc1   = '0;
    reqSrc2   = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset.respValid", {31'b0, respValid}, 32'd0);
    checkOutput("reset.reqReady", {30'b0, reqReady}, 32'd0);
    checkOutput("reset.respId", {31'b0, respId}, 32'd0);
    checkOutput("reset.int", respIntResult, 32'd0);
    checkOutput("reset.fp", respFpResult, 32'd0);
    checkOutput("reset.flags", {27'b0, flagBits}, 32'd0);

    runOp("eqOne",   0, CMP_EQ,  32'h3F800000, 32'h3F800000, 32'd1, 32'd0, 5'b00000);
    runOp("minR1",   1, CMP_MIN, 32'h40000000, 32'h3F800000, 32'd0, 32'h3F800000, 5'b00000);
    runOp("ltQnan",  1, CMP_LT,  32'h3F800000, 32'h7FC00000, 32'd0, 32'd0, 5'b10000);
    runOp("eqSnan",  0, CMP_EQ,  32'h7F800001, 32'h3F800000, 32'd0, 32'd0, 5'b10000);
    runOp("maxZero", 0, CMP_MAX, 32'h80000000, 32'h00000000, 32'd0, 32'h00000000, 5'b00000);
    runOp("leNeg",   1, CMP_LE,  32'hC0000000, 32'hBF800000, 32'd1, 32'd0, 5'b00000);

    // Contention from a fresh reset so the first tie goes to requester 0.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    setReq(0, CMP_EQ, 32'h3F800000, 32'h3F800000);
    setReq(1, CMP_LT, 32'h3F800000, 32'h40000000);
    reqValid  = 2'b11;
    respReady = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (reqReady != 2'b00) begin
        gIdx.push_back(int'(reqReady[1]));
        gCyc.push_back(k);
      end
    end
    applyStimulus(2'b00, 1'b1);
`ifdef FP_CMP_ARB_ROUND_ROBIN_EN
    expSeq = '{0, 1, 0};
`else
    expSeq = '{0, 0, 0};
`endif
    checkOutput("arb.grantCount", 32'(gIdx.size()), 32'd5);
    if (gIdx.size() >= 3) begin
      for (int i = 0; i < 3; i++) checkOutput($sformatf("arb.grant%0d", i), 32'(gIdx[i]), 32'(expSeq[i]));
      checkOutput("arb.spacing", 32'(gCyc[1] - gCyc[0]), 32'd2);
    end
    repeat (3) @(negedge clk);

    // Backpressure: response held for five cycles while requester 1 waits.
    applyStimulus(2'b01, 1'b0);
    setReq(0, CMP_MAX, 32'hC0000000, 32'h3F800000);
    @(negedge clk);
    checkOutput("bp.grant", {30'b0, reqReady}, 32'd1);
    applyStimulus(2'b10, 1'b0);
    setReq(1, CMP_LE, 32'h3F800000, 32'h3F800000);
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      if (respValid) got = 1'b1;
    end
    checkOutput("bp.respSeen", {31'b0, got}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("bp.holdReady", {30'b0, reqReady}, 32'd0);
      checkOutput("bp.holdFp", respFpResult, 32'h3F800000);
    end
    @(posedge clk); #1 respReady = 1'b1;
    @(negedge clk);
    checkOutput("bp.releaseGrant", {30'b0, reqReady}, 32'd2);
    @(posedge clk); #1 reqValid = 2'b00;
    @(negedge clk);
    checkOutput("bp.execNoValid", {31'b0, respValid}, 32'd0);
    @(negedge clk);
    checkOutput("bp.nextValid", {31'b0, respValid}, 32'd1);
    checkOutput("bp.nextId", {31'b0, respId}, 32'd1);
    checkOutput("bp.nextInt", respIntResult, 32'd1);

    // Reset while the comparator is executing discards the operation.
    applyStimulus(2'b01, 1'b1);
    setReq(0, CMP_MIN, 32'h40400000, 32'h3F800000);
    @(negedge clk);
    checkOutput("rstExec.grant", {30'b0, reqReady}, 32'd1);
    @(posedge clk); #1 reqValid = 2'b00; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rstExec.respValid", {31'b0, respValid}, 32'd0);
    checkOutput("rstExec.int", respIntResult, 32'd0);
    checkOutput("rstExec.fp", respFpResult, 32'd0);
    @(negedge clk);
    checkOutput("rstExec.respValidLater", {31'b0, respValid}, 32'd0);
    runOp("afterRst", 0, CMP_MIN, 32'h40400000, 32'h3F800000, 32'd0, 32'h3F800000, 5'b00000);

    // A request raised during reset is not taken.
    @(posedge clk); #1 rst = 1'b1; reqValid = 2'b11;
    @(negedge clk);
    checkOutput("rstReq.ready", {30'b0, reqReady}, 32'd0);
    @(posedge clk); #1 rst = 1'b0; reqValid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstReq.noResp", {31'b0, respValid}, 32'd0);

    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 99) == 0);
      reqValid  = 2'($urandom_range(0, 3));
      respReady = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 2; i++) begin
        reqCommand[i] = FpComparatorCommand'($urandom_range(0, 4));
        reqSrc1[i]    = randOperand();
        reqSrc2[i]    = ($urandom_range(0, 3) == 0) ? reqSrc1[i] : randOperand();
      end
    end
    applyStimulus(2'b00, 1'b1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
